ecc_82_scrub_ctrl: RTL
======================

Name: ecc_82_scrub_ctrl

Overview:
- Sits directly downstream of the 82-bit ECC fault-detect stage on the FIFO read path.
- Consumes the corrected read data and the sbit/dbit/fault flags for each read.
- On a correctable single-bit error, it issues one write-back (scrub) of the corrected word to the same address over a req/ack handshake.
- Keeps saturating error statistics and a sticky first-error log, and raises an interrupt on uncorrectable events.

Parameters:
DATA_WIDTH, 82, width of the corrected data word
ADDR_WIDTH, 6, FIFO RAM address width
CNT_WIDTH, 16, width of each statistics counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rd_vld  input  1  read result valid this cycle; the flags below are qualified by it
rd_addr  input  ADDR_WIDTH  RAM address of the read
data_corr  input  DATA_WIDTH  corrected data from the fault-detect stage
sbit_err  input  1  single-bit error, correctable
dbit_err  input  1  double-bit error, uncorrectable
ecc_fault  input  1  dual-decoder mismatch; data_corr is raw
scrub_en  input  1  enables new scrub requests
clr  input  1  clears counters, log and irq
scrub_req  output  1  write-back request
scrub_ack  input  1  write port accepts the request
scrub_addr  output  ADDR_WIDTH  write-back address
scrub_data  output  DATA_WIDTH  write-back data
sbit_cnt  output  CNT_WIDTH  count of qualified sbit events
dbit_cnt  output  CNT_WIDTH  count of qualified dbit events
fault_cnt  output  CNT_WIDTH  count of qualified fault events
drop_cnt  output  CNT_WIDTH  count of scrubs dropped because one was already pending
err_vld  output  1  first-error log valid
err_addr  output  ADDR_WIDTH  address of the first error
err_type  output  2  01 sbit, 10 dbit, 11 fault
irq  output  1  level interrupt

Behaviour:
- All outputs are registered. Reset value is 0 for every output; the FSM resets to IDLE.
- Event classification applies only when rd_vld=1. Precedence: ecc_fault > dbit_err > sbit_err, and exactly one class is counted per read.
  - fault: fault_cnt+1
  - dbit: dbit_cnt+1
  - sbit (sbit_err=1, dbit_err=0, ecc_fault=0): sbit_cnt+1
- Counters update the cycle after rd_vld, saturate at all-ones, and do not wrap.
- clr:
  - Counters go to 0 and the log is cleared.
  - An event in the same cycle is applied after the clear: the counter becomes 1 and the log captures that event.
  - clr does not affect the FSM or the scrub outputs.
- First-error log: captures rd_addr/err_type on the first classified event while err_vld=0, then holds (sticky) until clr.
- irq = 1 while any of the following is true: err_vld=1 with err_type≠01, dbit_cnt≠0, or fault_cnt≠0. It is cleared by clr.
- Scrub FSM, states IDLE and REQ:
  - Scrub trigger: rd_vld=1, class sbit, scrub_en=1. Dbit and fault events never scrub.
  - IDLE + trigger: latch rd_addr/data_corr, go to REQ. scrub_req=1 in the next cycle (1-cycle latency).
  - REQ: scrub_req, scrub_addr and scrub_data are held stable until a cycle with scrub_ack=1.
  - REQ + ack, no trigger: go to IDLE, scrub_req=0 the next cycle.
  - REQ + ack + trigger in the same cycle: latch the new payload and stay in REQ (back-to-back, no bubble).
  - REQ + trigger without ack: the new scrub is dropped, drop_cnt+1 (saturating); the pending payload is unchanged.
  - scrub_ack while in IDLE is ignored.
  - scrub_en deasserted while in REQ: the pending request still completes.
- Reset mid-operation: any pending scrub is discarded and all state is cleared in the same edge.

Test Plan:
- Reset, then rd_vld with sbit_err at addr 0x05, data 0x1_2345 → next cycle: scrub_req=1, scrub_addr=0x05, scrub_data=0x1_2345, sbit_cnt=1, err_vld=1, err_type=01, irq=0. scrub_ack on cycle 3 → scrub_req=0 on cycle 4.
- Hold scrub_ack=0 and issue 3 more sbit reads at addrs 0x06–0x08 → drop_cnt=3, scrub_addr stays 0x05, sbit_cnt=4.
- In REQ, assert scrub_ack together with a new sbit at addr 0x10 → scrub_req stays 1 with no gap, scrub_addr=0x10.
- rd_vld with sbit_err=1, dbit_err=1 and ecc_fault=1 at addr 0x3F → fault_cnt=1, sbit_cnt and dbit_cnt unchanged, no scrub, irq=1. A later dbit read does not change err_addr (0x3F) or err_type (11).
- Preload a counter to all-ones (CNT_WIDTH=4, 16 dbit events) → dbit_cnt stays 0xF. clr in the same cycle as a dbit read → dbit_cnt=1, err_type=10.
- Assert rst while in REQ → scrub_req=0, all counters 0, err_vld=0 next cycle. A subsequent scrub_ack has no effect.

Source files
------------

// File: rtl/ecc_82_scrub_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : ecc_82_scrub_ctrl
// Brief   : ECC read-path scrub write-back controller with error statistics,
//           sticky first-error log and uncorrectable-event interrupt.
// Rev     : 1.0 - initial release
// =============================================================================
module ecc_82_scrub_ctrl #(
   parameter int DATA_WIDTH = 82,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_vld,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] data_corr,
   input  logic                  sbit_err,
   input  logic                  dbit_err,
   input  logic                  ecc_fault,
   input  logic                  scrub_en,
   input  logic                  clr,
   output logic                  scrub_req,
   input  logic                  scrub_ack,
   output logic [ADDR_WIDTH-1:0] scrub_addr,
   output logic [DATA_WIDTH-1:0] scrub_data,
   output logic [CNT_WIDTH-1:0]  sbit_cnt,
   output logic [CNT_WIDTH-1:0]  dbit_cnt,
   output logic [CNT_WIDTH-1:0]  fault_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  err_vld,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic [1:0]            err_type,
   output logic                  irq
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                  r_state;
   logic                    w_fault, w_dbit, w_sbit, w_event, w_trig, w_drop;
   logic [1:0]              w_type;
   logic [CNT_WIDTH-1:0]    w_sbit_nxt, w_dbit_nxt, w_fault_nxt, w_drop_nxt;
   logic                    w_log_vld_nxt;
   logic [ADDR_WIDTH-1:0]   w_log_addr_nxt;
   logic [1:0]              w_log_type_nxt;
   logic                    w_irq_nxt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic inc);
      if (inc && (v != {CNT_WIDTH{1'b1}}))
         return v + c_cnt_one;
      return v;
   endfunction

   // Exactly one class per qualified read: fault beats dbit beats sbit.
   assign w_fault = rd_vld & ecc_fault;
   assign w_dbit  = rd_vld & ~ecc_fault & dbit_err;
   assign w_sbit  = rd_vld & ~ecc_fault & ~dbit_err & sbit_err;
   assign w_event = w_fault | w_dbit | w_sbit;
   assign w_type  = w_fault ? 2'b11 : (w_dbit ? 2'b10 : 2'b01);
   assign w_trig  = w_sbit & scrub_en;
   assign w_drop  = (r_state == REQ) & w_trig & ~scrub_ack;

   // Clear is applied first so a same-cycle event lands on a fresh counter/log.
   assign w_sbit_nxt  = sat_inc(clr ? '0 : sbit_cnt,  w_sbit);
   assign w_dbit_nxt  = sat_inc(clr ? '0 : dbit_cnt,  w_dbit);
   assign w_fault_nxt = sat_inc(clr ? '0 : fault_cnt, w_fault);
   assign w_drop_nxt  = sat_inc(clr ? '0 : drop_cnt,  w_drop);

   always_comb begin
      w_log_vld_nxt  = err_vld & ~clr;
      w_log_addr_nxt = clr ? '0 : err_addr;
      w_log_type_nxt = clr ? 2'b00 : err_type;
      if (!w_log_vld_nxt && w_event) begin
         w_log_vld_nxt  = 1'b1;
         w_log_addr_nxt = rd_addr;
         w_log_type_nxt = w_type;
      end
   end

   assign w_irq_nxt = (w_log_vld_nxt && (w_log_type_nxt != 2'b01)) ||
                      (w_dbit_nxt != '0) || (w_fault_nxt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sbit_cnt  <= '0;
         dbit_cnt  <= '0;
         fault_cnt <= '0;
         drop_cnt  <= '0;
         err_vld   <= 1'b0;
         err_addr  <= '0;
         err_type  <= 2'b00;
         irq       <= 1'b0;
      end else begin
         sbit_cnt  <= w_sbit_nxt;
         dbit_cnt  <= w_dbit_nxt;
         fault_cnt <= w_fault_nxt;
         drop_cnt  <= w_drop_nxt;
         err_vld   <= w_log_vld_nxt;
         err_addr  <= w_log_addr_nxt;
         err_type  <= w_log_type_nxt;
         irq       <= w_irq_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         scrub_req  <= 1'b0;
         scrub_addr <= '0;
         scrub_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_trig) begin
                  r_state    <= REQ;
                  scrub_req  <= 1'b1;
                  scrub_addr <= rd_addr;
                  scrub_data <= data_corr;
               end
            end
            REQ: begin
               // Ack plus a new trigger reloads the payload with no idle bubble.
               if (scrub_ack) begin
                  if (w_trig) begin
                     scrub_addr <= rd_addr;
                     scrub_data <= data_corr;
                  end else begin
                     r_state   <= IDLE;
                     scrub_req <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= IDLE;
               scrub_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
